// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// trap_ctrl_if : commit, CSR and redirect signals of the trap sequencer
// Rev 1.0
// ============================================================================
interface trap_ctrl_if #(
  parameter int XLEN = 64
);
  // commit stage
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            commit_exc;
  logic [3:0]      commit_cause;
  logic [XLEN-1:0] commit_tval;
  logic            commit_mret;
  logic            commit_ready;
  logic            commit_kill;
  // CSR file
  logic            mstatus_mie;
  logic [1:0]      mstatus_mpp;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [1:0]      priv;
  logic            trap_we;
  logic [XLEN-1:0] trap_mepc;
  logic [XLEN-1:0] trap_mcause;
  logic [XLEN-1:0] trap_mtval;
  logic            mret_we;
  logic [1:0]      priv_nxt;
  // front end
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output commit_valid, commit_pc, commit_exc, commit_cause, commit_tval, commit_mret,
    output mstatus_mie, mstatus_mpp, mie, mip, mtvec, mepc, priv, redirect_ready,
    input  commit_ready, commit_kill, trap_we, trap_mepc, trap_mcause, trap_mtval,
    input  mret_we, priv_nxt, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, commit_exc, commit_cause, commit_tval, commit_mret,
    input  mstatus_mie, mstatus_mpp, mie, mip, mtvec, mepc, priv, redirect_ready,
    output commit_ready, commit_kill, trap_we, trap_mepc, trap_mcause, trap_mtval,
    output mret_we, priv_nxt, flush, redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// trap_ctrl : trap / MRET sequencer between commit and the CSR file
// Rev 1.0
// ============================================================================
module trap_ctrl #(
  parameter int XLEN        = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input  wire logic   clk,
  input  wire logic   reset,
  trap_ctrl_if.slave  tc_if
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ENTER    = 2'd1,
    S_MRET     = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  localparam logic [1:0]      PRIV_M   = 2'b11;
  localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);

  state_t          state_q;
  logic [XLEN-1:0] mepc_q;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] tval_q;
  logic            irq_q;
  logic [XLEN-1:0] target_q;
  logic [1:0]      mpp_q;

  logic [XLEN-1:0] pend_d;
  logic            irq_en_d;
  logic            take_irq_d;
  logic [3:0]      irq_code_d;
  logic [XLEN-1:0] base_d;
  logic [XLEN-1:0] irq_target_d;
  logic            decide_d;

  assign pend_d     = tc_if.mip & tc_if.mie & IRQ_MASK;
  assign irq_en_d   = (tc_if.priv != PRIV_M) | tc_if.mstatus_mie;
  assign take_irq_d = (|pend_d) & irq_en_d;

  // Fixed priority among the machine-level sources: external, software, timer.
  always_comb begin
    irq_code_d = 4'd7;
    if (pend_d[11])     irq_code_d = 4'd11;
    else if (pend_d[3]) irq_code_d = 4'd3;
  end

  assign base_d       = tc_if.mtvec & ~XLEN'(3);
  assign irq_target_d = (VECTORED_EN && (tc_if.mtvec[1:0] == 2'b01))
                        ? base_d + (XLEN'(irq_code_d) << 2) : base_d;
  assign decide_d     = (state_q == S_IDLE) & tc_if.commit_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mepc_q   <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      irq_q    <= 1'b0;
      target_q <= '0;
      mpp_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tc_if.commit_valid) begin
            if (take_irq_d) begin
              mepc_q   <= tc_if.commit_pc;
              cause_q  <= irq_code_d;
              tval_q   <= '0;
              irq_q    <= 1'b1;
              target_q <= irq_target_d;
              state_q  <= S_ENTER;
            end else if (tc_if.commit_exc) begin
              mepc_q   <= tc_if.commit_pc;
              cause_q  <= tc_if.commit_cause;
              tval_q   <= tc_if.commit_tval;
              irq_q    <= 1'b0;
              target_q <= base_d;
              state_q  <= S_ENTER;
            end else if (tc_if.commit_mret) begin
              target_q <= tc_if.mepc & ~XLEN'(3);
              mpp_q    <= tc_if.mstatus_mpp;
              state_q  <= S_MRET;
            end
          end
        end
        S_ENTER:    state_q <= S_REDIRECT;
        S_MRET:     state_q <= S_REDIRECT;
        S_REDIRECT: if (tc_if.redirect_ready) state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  assign tc_if.commit_ready   = (state_q == S_IDLE);
  assign tc_if.commit_kill    = decide_d & (take_irq_d | tc_if.commit_exc);
  assign tc_if.trap_we        = (state_q == S_ENTER);
  assign tc_if.mret_we        = (state_q == S_MRET);
  assign tc_if.flush          = (state_q != S_IDLE);
  assign tc_if.redirect_valid = (state_q == S_REDIRECT);
  assign tc_if.redirect_pc    = target_q;
  assign tc_if.trap_mepc      = mepc_q;
  assign tc_if.trap_mcause    = irq_q ? {1'b1, {(XLEN-5){1'b0}}, cause_q}
                                      : {{(XLEN-4){1'b0}}, cause_q};
  assign tc_if.trap_mtval     = tval_q;
  assign tc_if.priv_nxt       = (state_q == S_ENTER) ? PRIV_M :
                                (state_q == S_MRET)  ? mpp_q  : tc_if.priv;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// tb_trap_ctrl : directed self-checking bench for trap_ctrl
// Rev 1.0
// ============================================================================
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;

  trap_ctrl_if #(.XLEN(64)) bus ();

  trap_ctrl #(.XLEN(64), .VECTORED_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .tc_if (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    bus.commit_valid = 1'b0;
    bus.commit_exc   = 1'b0;
    bus.commit_mret  = 1'b0;
    bus.commit_cause = 4'd0;
    bus.commit_tval  = '0;
    bus.commit_pc    = '0;
  endtask

  task automatic test_reset();
    clear_commit();
    bus.mstatus_mie = 1'b0; bus.mstatus_mpp = 2'd0;
    bus.mie = '0; bus.mip = '0; bus.mtvec = 64'h8000_0101; bus.mepc = '0;
    bus.priv = 2'd1; bus.redirect_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    total++; if (bus.commit_ready !== 1'b1) $display("FAIL rst_ready: got %h expected 1", bus.commit_ready); else passed++;
    total++; if (bus.trap_we !== 1'b0) $display("FAIL rst_trap_we: got %h expected 0", bus.trap_we); else passed++;
    total++; if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) $display("FAIL rst_flush_rv: got %b%b expected 00", bus.flush, bus.redirect_valid); else passed++;
    total++; if (bus.priv_nxt !== 2'd1) $display("FAIL rst_priv_nxt: got %h expected 1", bus.priv_nxt); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ecall();
    bus.priv = 2'd0;
    bus.commit_valid = 1'b1; bus.commit_exc = 1'b1; bus.commit_cause = 4'd8;
    bus.commit_pc = 64'h8000_0010; bus.commit_tval = 64'h0;
    #1;
    total++; if (bus.commit_kill !== 1'b1) $display("FAIL t1_kill: got %h expected 1", bus.commit_kill); else passed++;
    tick(); clear_commit();
    total++; if (bus.trap_we !== 1'b1 || bus.mret_we !== 1'b0) $display("FAIL t1_trap_we: got %b%b expected 10", bus.trap_we, bus.mret_we); else passed++;
    total++; if (bus.trap_mepc !== 64'h8000_0010) $display("FAIL t1_mepc: got %h expected 80000010", bus.trap_mepc); else passed++;
    total++; if (bus.trap_mcause !== 64'd8) $display("FAIL t1_mcause: got %h expected 8", bus.trap_mcause); else passed++;
    total++; if (bus.priv_nxt !== 2'd3 || bus.commit_ready !== 1'b0 || bus.flush !== 1'b1) $display("FAIL t1_enter: got priv %h ready %h flush %h expected 3 0 1", bus.priv_nxt, bus.commit_ready, bus.flush); else passed++;
    tick();
    total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 64'h8000_0100) $display("FAIL t1_redirect: got %h %h expected 1 80000100", bus.redirect_valid, bus.redirect_pc); else passed++;
    total++; if (bus.trap_we !== 1'b0 || bus.priv_nxt !== 2'd0) $display("FAIL t1_post_enter: got we %h priv %h expected 0 0", bus.trap_we, bus.priv_nxt); else passed++;
    bus.redirect_ready = 1'b1;
    tick(); bus.redirect_ready = 1'b0;
    total++; if (bus.commit_ready !== 1'b1 || bus.redirect_valid !== 1'b0) $display("FAIL t1_idle: got ready %h rv %h expected 1 0", bus.commit_ready, bus.redirect_valid); else passed++;
  endtask

  task automatic test_irq_vectored();
    bus.priv = 2'd3; bus.mstatus_mie = 1'b1;
    bus.mip = 64'h80; bus.mie = 64'h80; bus.mtvec = 64'h8000_0101;
    bus.commit_valid = 1'b1; bus.commit_pc = 64'h100;
    #1;
    total++; if (bus.commit_kill !== 1'b1) $display("FAIL t2_kill: got %h expected 1", bus.commit_kill); else passed++;
    tick(); clear_commit(); bus.mip = '0;
    total++; if (bus.trap_mcause !== 64'h8000_0000_0000_0007) $display("FAIL t2_mcause: got %h expected 8000000000000007", bus.trap_mcause); else passed++;
    total++; if (bus.trap_mepc !== 64'h100 || bus.trap_mtval !== 64'h0) $display("FAIL t2_mepc_mtval: got %h %h expected 100 0", bus.trap_mepc, bus.trap_mtval); else passed++;
    tick();
    total++; if (bus.redirect_pc !== 64'h8000_011C) $display("FAIL t2_redirect_pc: got %h expected 8000011c", bus.redirect_pc); else passed++;
    bus.redirect_ready = 1'b1; tick(); bus.redirect_ready = 1'b0;
  endtask

  task automatic test_irq_masking();
    bus.priv = 2'd3; bus.mstatus_mie = 1'b0;
    bus.mip = 64'h80; bus.mie = 64'h80;
    // Pending interrupt without a committing instruction must not be taken
    bus.priv = 2'd0;
    tick();
    total++; if (bus.commit_ready !== 1'b1 || bus.trap_we !== 1'b0) $display("FAIL t3_no_commit: got ready %h we %h expected 1 0", bus.commit_ready, bus.trap_we); else passed++;
    bus.priv = 2'd3;
    bus.commit_valid = 1'b1; bus.commit_pc = 64'h104;
    #1;
    total++; if (bus.commit_kill !== 1'b0) $display("FAIL t3_masked_kill: got %h expected 0", bus.commit_kill); else passed++;
    tick();
    total++; if (bus.commit_ready !== 1'b1 || bus.trap_we !== 1'b0) $display("FAIL t3_masked: got ready %h we %h expected 1 0", bus.commit_ready, bus.trap_we); else passed++;
    bus.priv = 2'd0;
    #1;
    total++; if (bus.commit_kill !== 1'b1) $display("FAIL t3_umode_kill: got %h expected 1", bus.commit_kill); else passed++;
    tick(); clear_commit(); bus.mip = '0;
    total++; if (bus.trap_we !== 1'b1 || bus.trap_mcause !== 64'h8000_0000_0000_0007 || bus.trap_mepc !== 64'h104) $display("FAIL t3_umode_trap: got we %h cause %h mepc %h expected 1 8000000000000007 104", bus.trap_we, bus.trap_mcause, bus.trap_mepc); else passed++;
    tick(); bus.redirect_ready = 1'b1; tick(); bus.redirect_ready = 1'b0;
  endtask

  task automatic test_irq_priority();
    bus.priv = 2'd3; bus.mstatus_mie = 1'b1;
    bus.mip = 64'h888; bus.mie = 64'h880;
    bus.commit_valid = 1'b1; bus.commit_exc = 1'b1; bus.commit_cause = 4'd2;
    bus.commit_tval = 64'hDEAD; bus.commit_pc = 64'h300;
    tick(); clear_commit(); bus.mip = '0;
    total++; if (bus.trap_mcause !== 64'h8000_0000_0000_000B) $display("FAIL t4_mcause: got %h expected 800000000000000b", bus.trap_mcause); else passed++;
    total++; if (bus.trap_mtval !== 64'h0) $display("FAIL t4_mtval: got %h expected 0", bus.trap_mtval); else passed++;
    tick();
    total++; if (bus.redirect_pc !== 64'h8000_012C) $display("FAIL t4_redirect_pc: got %h expected 8000012c", bus.redirect_pc); else passed++;
    bus.redirect_ready = 1'b1; tick(); bus.redirect_ready = 1'b0;
  endtask

  task automatic test_mret();
    bus.priv = 2'd3; bus.mepc = 64'h2002; bus.mstatus_mpp = 2'd0;
    bus.commit_valid = 1'b1; bus.commit_mret = 1'b1; bus.commit_pc = 64'h400;
    #1;
    total++; if (bus.commit_kill !== 1'b0) $display("FAIL t5_kill: got %h expected 0", bus.commit_kill); else passed++;
    tick(); clear_commit(); bus.mstatus_mpp = 2'd3;
    total++; if (bus.mret_we !== 1'b1 || bus.trap_we !== 1'b0 || bus.priv_nxt !== 2'd0 || bus.flush !== 1'b1) $display("FAIL t5_mret_we: got mret %h trap %h priv %h flush %h expected 1 0 0 1", bus.mret_we, bus.trap_we, bus.priv_nxt, bus.flush); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 64'h2000 || bus.commit_ready !== 1'b0 || bus.mret_we !== 1'b0) $display("FAIL t5_hold%0d: got rv %h pc %h ready %h mret %h expected 1 2000 0 0", i, bus.redirect_valid, bus.redirect_pc, bus.commit_ready, bus.mret_we); else passed++;
    end
    bus.redirect_ready = 1'b1; tick(); bus.redirect_ready = 1'b0;
    total++; if (bus.commit_ready !== 1'b1 || bus.flush !== 1'b0) $display("FAIL t5_idle: got ready %h flush %h expected 1 0", bus.commit_ready, bus.flush); else passed++;
  endtask

  task automatic test_reset_mid();
    bus.priv = 2'd1; bus.mtvec = 64'h0000_1000;
    bus.commit_valid = 1'b1; bus.commit_exc = 1'b1; bus.commit_cause = 4'd9; bus.commit_pc = 64'h500;
    tick(); clear_commit(); tick();
    total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 64'h1000) $display("FAIL t6_pre: got rv %h pc %h expected 1 1000", bus.redirect_valid, bus.redirect_pc); else passed++;
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0 || bus.trap_we !== 1'b0) $display("FAIL t6_outs: got rv %h flush %h we %h expected 0 0 0", bus.redirect_valid, bus.flush, bus.trap_we); else passed++;
    total++; if (bus.commit_ready !== 1'b1 || bus.priv_nxt !== 2'd1) $display("FAIL t6_ready: got ready %h priv %h expected 1 1", bus.commit_ready, bus.priv_nxt); else passed++;
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_irq_vectored();
    test_irq_masking();
    test_irq_priority();
    test_mret();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
